// File: rtl/thread_sched.sv
// Fetch-side thread scheduler: per-thread PC and run state, round-robin pick of the next
// runnable thread, registered {thread id, PC} fetch request.
module thread_sched #(
   parameter int unsigned     NUM_THREADS = 8,
   parameter int unsigned     PC_W        = 32,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   jmp,
   input  logic [2:0]             jmp_trd,
   input  logic [PC_W-1:0]        jmp_target,
   input  logic                   kill,
   input  logic                   sleep,
   input  logic                   d_miss,
   input  logic [2:0]             trd_wb,
   input  logic [PC_W-1:0]        wb_pc,
   input  logic                   miss_done,
   input  logic [2:0]             miss_trd,
   input  logic                   wake,
   input  logic [2:0]             wake_trd,
   input  logic                   spawn,
   input  logic [2:0]             spawn_trd,
   input  logic [PC_W-1:0]        spawn_pc,
   output logic                   if_valid,
   output logic [2:0]             trd_if,
   output logic [PC_W-1:0]        pc_if,
   output logic [NUM_THREADS-1:0] active_mask
);

   localparam int unsigned TW = 3;

   logic [NUM_THREADS-1:0] active_q, active_d;
   logic [NUM_THREADS-1:0] asleep_q, asleep_d;
   logic [NUM_THREADS-1:0] blocked_q, blocked_d;
   logic [PC_W-1:0]        pc_q [NUM_THREADS];
   logic [PC_W-1:0]        pc_d [NUM_THREADS];
   logic [NUM_THREADS-1:0] redirect;
   logic [NUM_THREADS-1:0] runnable;
   logic [TW-1:0]          last_q;
   logic [TW-1:0]          sel;
   logic                   sel_found;
   logic                   if_valid_q;
   logic [TW-1:0]          trd_if_q;
   logic [PC_W-1:0]        pc_if_q;

   // A thread redirected this cycle is held back so its old PC is never issued.
   always_comb begin
      redirect = '0;
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
         redirect[t] = ((kill || d_miss || sleep) && trd_wb == TW'(t)) ||
                       (jmp && jmp_trd == TW'(t));
      end
      runnable = active_q & ~asleep_q & ~blocked_q & ~redirect;
   end

   always_comb begin
      sel       = last_q;
      sel_found = 1'b0;
      for (int i = 1; i <= int'(NUM_THREADS); i++) begin
         if (!sel_found && runnable[TW'((int'(last_q) + i) % int'(NUM_THREADS))]) begin
            sel       = TW'((int'(last_q) + i) % int'(NUM_THREADS));
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      active_d  = active_q;
      asleep_d  = asleep_q;
      blocked_d = blocked_q;
      pc_d      = pc_q;
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
         // Clears go first so a same-cycle set below overrides them.
         if (miss_done && miss_trd == TW'(t)) blocked_d[t] = 1'b0;
         if (wake && wake_trd == TW'(t)) asleep_d[t] = 1'b0;
         if (kill && trd_wb == TW'(t)) begin
            active_d[t]  = 1'b0;
            asleep_d[t]  = 1'b0;
            blocked_d[t] = 1'b0;
         end else if (d_miss && trd_wb == TW'(t)) begin
            pc_d[t]      = wb_pc;
            blocked_d[t] = 1'b1;
         end else if (sleep && trd_wb == TW'(t)) begin
            pc_d[t]     = wb_pc + PC_W'(4);
            asleep_d[t] = 1'b1;
         end else if (jmp && jmp_trd == TW'(t)) begin
            pc_d[t] = jmp_target;
         end else if (spawn && spawn_trd == TW'(t) && !active_q[t]) begin
            active_d[t]  = 1'b1;
            asleep_d[t]  = 1'b0;
            blocked_d[t] = 1'b0;
            pc_d[t]      = spawn_pc;
         end else if (!stall && sel_found && sel == TW'(t)) begin
            pc_d[t] = pc_q[t] + PC_W'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q   <= NUM_THREADS'(1);
         asleep_q   <= '0;
         blocked_q  <= '0;
         pc_q       <= '{default: '0};
         pc_q[0]    <= RESET_PC;
         if_valid_q <= 1'b0;
         trd_if_q   <= '0;
         pc_if_q    <= '0;
         last_q     <= TW'(NUM_THREADS - 1);
      end else begin
         active_q  <= active_d;
         asleep_q  <= asleep_d;
         blocked_q <= blocked_d;
         pc_q      <= pc_d;
         if (!stall) begin
            if_valid_q <= sel_found;
            if (sel_found) begin
               trd_if_q <= sel;
               pc_if_q  <= pc_q[sel];
               last_q   <= sel;
            end
         end
      end
   end

   assign if_valid    = if_valid_q;
   assign trd_if      = trd_if_q;
   assign pc_if       = pc_if_q;
   assign active_mask = active_q;

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: round-robin issue, stall freeze, redirects, kill, PC wrap
// and mid-run reset, with hand-computed expected fetch streams.
module tb_thread_sched;

   logic        clk = 1'b0;
   logic        rst, stall, jmp, kill, sleep, d_miss, miss_done, wake, spawn;
   logic [2:0]  jmp_trd, trd_wb, miss_trd, wake_trd, spawn_trd;
   logic [31:0] jmp_target, wb_pc, spawn_pc;
   logic        if_valid;
   logic [2:0]  trd_if;
   logic [31:0] pc_if;
   logic [7:0]  active_mask;

   int n_checks = 0;
   int n_fail   = 0;

   thread_sched #(
      .NUM_THREADS(8),
      .PC_W       (32),
      .RESET_PC   (32'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .jmp        (jmp),
      .jmp_trd    (jmp_trd),
      .jmp_target (jmp_target),
      .kill       (kill),
      .sleep      (sleep),
      .d_miss     (d_miss),
      .trd_wb     (trd_wb),
      .wb_pc      (wb_pc),
      .miss_done  (miss_done),
      .miss_trd   (miss_trd),
      .wake       (wake),
      .wake_trd   (wake_trd),
      .spawn      (spawn),
      .spawn_trd  (spawn_trd),
      .spawn_pc   (spawn_pc),
      .if_valid   (if_valid),
      .trd_if     (trd_if),
      .pc_if      (pc_if),
      .active_mask(active_mask)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [2:0] t,
                          input logic [31:0] pc);
      chk({tag, ".valid"}, 32'(if_valid), 32'(v));
      chk({tag, ".trd"}, 32'(trd_if), 32'(t));
      chk({tag, ".pc"}, pc_if, pc);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; jmp = 1'b0; kill = 1'b0; sleep = 1'b0; d_miss = 1'b0;
      miss_done = 1'b0; wake = 1'b0; spawn = 1'b0;
      jmp_trd = '0; trd_wb = '0; miss_trd = '0; wake_trd = '0; spawn_trd = '0;
      jmp_target = '0; wb_pc = '0; spawn_pc = '0;
      step(); step();
      chk_out("reset", 1'b0, 3'd0, 32'h0);
      chk("reset.mask", 32'(active_mask), 32'h01);

      // Single thread issues every cycle.
      rst = 1'b0;
      step(); chk_out("t0.a", 1'b1, 3'd0, 32'h0);
      step(); chk_out("t0.b", 1'b1, 3'd0, 32'h4);
      step(); chk_out("t0.c", 1'b1, 3'd0, 32'h8);
      step(); chk_out("t0.d", 1'b1, 3'd0, 32'hC);
      chk("t0.mask", 32'(active_mask), 32'h01);

      // Spawn threads 1 and 2, then round-robin 0,1,2.
      spawn = 1'b1; spawn_trd = 3'd1; spawn_pc = 32'h100;
      step(); chk_out("spawn1", 1'b1, 3'd0, 32'h10);
      spawn_trd = 3'd2; spawn_pc = 32'h200;
      step(); chk_out("spawn2", 1'b1, 3'd1, 32'h100);
      spawn = 1'b0;
      chk("spawn.mask", 32'(active_mask), 32'h07);
      step(); chk_out("rr.2a", 1'b1, 3'd2, 32'h200);
      step(); chk_out("rr.0a", 1'b1, 3'd0, 32'h14);
      step(); chk_out("rr.1a", 1'b1, 3'd1, 32'h104);
      step(); chk_out("rr.2b", 1'b1, 3'd2, 32'h204);
      step(); chk_out("rr.0b", 1'b1, 3'd0, 32'h18);

      // Stall three cycles while a jump for thread 1 lands.
      stall = 1'b1; jmp = 1'b1; jmp_trd = 3'd1; jmp_target = 32'h400;
      step(); chk_out("stall.a", 1'b1, 3'd0, 32'h18);
      jmp = 1'b0;
      step(); chk_out("stall.b", 1'b1, 3'd0, 32'h18);
      step(); chk_out("stall.c", 1'b1, 3'd0, 32'h18);
      stall = 1'b0;
      step(); chk_out("jmp.t1", 1'b1, 3'd1, 32'h400);

      // Jump for thread 2 without stall: thread 2 skipped in the jump cycle.
      jmp = 1'b1; jmp_trd = 3'd2; jmp_target = 32'h300;
      step(); chk_out("jmp.skip", 1'b1, 3'd0, 32'h1C);
      jmp = 1'b0;
      step(); chk_out("jmp.t1b", 1'b1, 3'd1, 32'h404);
      step(); chk_out("jmp.t2", 1'b1, 3'd2, 32'h300);

      // Data miss on thread 2, replay at 0x208 after miss_done five cycles later.
      d_miss = 1'b1; trd_wb = 3'd2; wb_pc = 32'h208;
      step(); chk_out("miss.e0", 1'b1, 3'd0, 32'h20);
      d_miss = 1'b0;
      step(); chk_out("miss.e1", 1'b1, 3'd1, 32'h408);
      step(); chk_out("miss.e2", 1'b1, 3'd0, 32'h24);
      step(); chk_out("miss.e3", 1'b1, 3'd1, 32'h40C);
      step(); chk_out("miss.e4", 1'b1, 3'd0, 32'h28);
      miss_done = 1'b1; miss_trd = 3'd2;
      step(); chk_out("miss.e5", 1'b1, 3'd1, 32'h410);
      miss_done = 1'b0;
      step(); chk_out("miss.replay", 1'b1, 3'd2, 32'h208);

      // Sleep thread 1 at 0x40C, wake it later, resume at 0x410.
      sleep = 1'b1; trd_wb = 3'd1; wb_pc = 32'h40C;
      step(); chk_out("sleep.a", 1'b1, 3'd0, 32'h2C);
      sleep = 1'b0;
      step(); chk_out("sleep.b", 1'b1, 3'd2, 32'h20C);
      step(); chk_out("sleep.c", 1'b1, 3'd0, 32'h30);
      wake = 1'b1; wake_trd = 3'd1;
      step(); chk_out("wake.a", 1'b1, 3'd2, 32'h210);
      wake = 1'b0;
      step(); chk_out("wake.b", 1'b1, 3'd0, 32'h34);
      step(); chk_out("wake.t1", 1'b1, 3'd1, 32'h410);

      // Kill and spawn thread 0 together: kill wins.
      kill = 1'b1; trd_wb = 3'd0; spawn = 1'b1; spawn_trd = 3'd0; spawn_pc = 32'h800;
      step(); chk_out("kill0", 1'b1, 3'd2, 32'h214);
      kill = 1'b0; spawn = 1'b0;
      chk("kill0.mask", 32'(active_mask), 32'h06);
      step(); chk_out("kill0.b", 1'b1, 3'd1, 32'h414);
      step(); chk_out("kill0.c", 1'b1, 3'd2, 32'h218);

      // Kill remaining threads: fetch goes invalid, outputs hold.
      kill = 1'b1; trd_wb = 3'd1;
      step(); chk_out("kill1", 1'b1, 3'd2, 32'h21C);
      trd_wb = 3'd2;
      step(); chk_out("kill2", 1'b0, 3'd2, 32'h21C);
      kill = 1'b0;
      chk("killall.mask", 32'(active_mask), 32'h00);
      step(); chk_out("idle", 1'b0, 3'd2, 32'h21C);

      // Spawn thread 7 near the top of the address space: PC wraps to 0.
      spawn = 1'b1; spawn_trd = 3'd7; spawn_pc = 32'hFFFF_FFFC;
      step(); chk_out("wrap.spawn", 1'b0, 3'd2, 32'h21C);
      spawn = 1'b0;
      chk("wrap.mask", 32'(active_mask), 32'h80);
      step(); chk_out("wrap.a", 1'b1, 3'd7, 32'hFFFF_FFFC);
      step(); chk_out("wrap.b", 1'b1, 3'd7, 32'h0);

      // Mid-run reset discards all thread state.
      rst = 1'b1;
      step(); chk_out("rst2", 1'b0, 3'd0, 32'h0);
      chk("rst2.mask", 32'(active_mask), 32'h01);
      rst = 1'b0;
      step(); chk_out("rst2.run", 1'b1, 3'd0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/thread_sched.md
Name: thread_sched

Overview:
- Fetch-side thread scheduler. It sits directly upstream of the IF stage and of the flush/stall controller.
- Holds one PC and one run state per hardware thread, and picks the next runnable thread round-robin each cycle.
- Presents {thread id, PC} to instruction fetch.
- Applies redirects from the pipeline: jump, kill, sleep, data-miss replay.
- Its trd_if output is the thread tag the flush/stall controller compares against later stages.

Parameters:
- NUM_THREADS, 8, number of hardware threads (thread id width = 3 bits, fixed).
- PC_W, 32, PC width.
- RESET_PC, 32'h0, start PC of thread 0 after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  global pipeline stall from the flush/stall controller.
- jmp  in  1  taken jump/branch resolved in EX.
- jmp_trd  in  3  thread of the jump (= trd_exe).
- jmp_target  in  PC_W  jump target.
- kill  in  1  thread in WB executes kill.
- sleep  in  1  thread in WB executes sleep.
- d_miss  in  1  data-cache miss on the instruction in WB.
- trd_wb  in  3  thread of the WB instruction.
- wb_pc  in  PC_W  PC of the WB instruction.
- miss_done  in  1  pulse: outstanding miss of miss_trd is filled.
- miss_trd  in  3  thread whose miss completed.
- wake  in  1  pulse: wake a sleeping thread.
- wake_trd  in  3  thread to wake.
- spawn  in  1  start an inactive thread.
- spawn_trd  in  3  thread to start.
- spawn_pc  in  PC_W  start PC for the spawned thread.
- if_valid  out  1  fetch request valid.
- trd_if  out  3  thread being fetched.
- pc_if  out  PC_W  fetch PC.
- active_mask  out  NUM_THREADS  per-thread active bit.

Behaviour:

Reset (rst=1 at clk edge):
- active_mask = 8'b0000_0001; all sleep/miss-blocked bits = 0.
- pc[0] = RESET_PC; pc[1..7] = 0.
- if_valid = 0, trd_if = 0, pc_if = 0; round-robin pointer last = 7, so thread 0 wins first.
- Reset mid-operation discards all per-thread state.

Per-thread state:
- active, asleep, blocked, pc.
- Runnable = active & ~asleep & ~blocked & ~redirected_this_cycle.

Per-thread update at each edge, highest priority first. A per-thread update applies even when stall=1.
1. kill && trd_wb==t: active=0, asleep=0, blocked=0.
2. d_miss && trd_wb==t: pc=wb_pc (replay); blocked=1.
3. sleep && trd_wb==t: pc=wb_pc+4; asleep=1.
4. jmp && jmp_trd==t: pc=jmp_target.
5. spawn && spawn_trd==t && !active: active=1, pc=spawn_pc, asleep=0, blocked=0.
   - Spawn to an active thread is ignored.
   - Kill beats spawn in the same cycle.
6. Selected for fetch this cycle (t==sel, !stall): pc=pc+4, modulo 2^PC_W.

Clear conditions:
- miss_done && miss_trd==t clears blocked.
- wake && wake_trd==t clears asleep.
- Each is ignored if the thread is not in that state.
- Same-cycle set (rule 2/3) beats clear.

Selection (combinational, registered into outputs):
- sel = first runnable thread after last, searching cyclically (last+1 .. last+NUM_THREADS mod NUM_THREADS).
- A thread hit by any rule 1–4 in this cycle is not eligible this cycle, so no stale PC is issued.

Output registers, one-cycle latency from selection:
- stall=1: trd_if, pc_if, if_valid and last hold; no pc increment.
- stall=0 with a runnable thread: if_valid=1, trd_if=sel, pc_if=pc[sel] (pre-increment value), last=sel.
- stall=0 with no runnable thread: if_valid=0; trd_if and pc_if hold; last holds.

Other:
- A single active thread issues every cycle with PC +4 per cycle.
- All thread-index comparisons are 3-bit equality; NUM_THREADS=8 uses the full id space.

Test Plan:
- Reset then run 4 cycles → (trd_if,pc_if) = (0,0),(0,4),(0,8),(0,C); active_mask = 01.
- Spawn threads 1 and 2 at 0x100 and 0x200 → issue order 0,1,2,0,1,2; each thread's PC steps +4 on its own turn.
- stall=1 for 3 cycles while jmp for thread 1 to 0x400 arrives → outputs frozen; after release thread 1 issues 0x400 and is not issued in the jmp cycle.
- d_miss with trd_wb=2, wb_pc=0x208 → thread 2 skipped; miss_done(2) five cycles later → next thread-2 fetch at 0x208.
- sleep trd_wb=1 wb_pc=0x40C, then wake(1) → thread 1 resumes at 0x410.
- Same cycle: kill and spawn on thread 0 → thread 0 inactive. Kill every thread → if_valid=0 and outputs hold.
